// File: rtl/branch_resolver.sv
// ---------------------------------------------------------------------------
// branch_resolver
//
// Execute-stage branch resolution for the 16-bit pipelined CPU. For every
// valid, unstalled EX instruction this unit works out the architecturally
// correct next PC and compares it with the PC the fetch stage predicted.
//
// On a mismatch it issues a one-cycle registered redirect (force_pc /
// force_pc_data) and a pipeline flush. The unit then spends one cycle in
// REDIRECT, during which it ignores the wrong-path EX contents.
//
// Each resolved control instruction also produces a registered
// predictor-update record. Two saturating statistics counters are kept.
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   ex_valid              EX holds a real instruction
//   ex_stall              EX held this cycle (instruction not consumed)
//   ex_pc                 PC of the EX instruction
//   ex_instruction        opcode[15:12] rs[11:10] rt[9:8] imm[7:0] func[5:0]
//   ex_pred_pc            next PC the fetch stage chose after ex_pc
//   ex_rs_data/rt_data    forwarded register operands
//   force_pc              redirect pulse to the PC predictor
//   force_pc_data         redirect target (holds when force_pc is low)
//   flush                 kill IF/ID and ID/EX
//   upd_valid             predictor update record valid
//   upd_pc/target/taken   update record contents (hold when upd_valid low)
//   branch_count          resolved control instructions (saturating)
//   mispredict_count      redirects issued (saturating)
// ---------------------------------------------------------------------------
module branch_resolver #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic [15:0]      ex_pc,
  input  logic [15:0]      ex_instruction,
  input  logic [15:0]      ex_pred_pc,
  input  logic [15:0]      ex_rs_data,
  input  logic [15:0]      ex_rt_data,
  output logic             force_pc,
  output logic [15:0]      force_pc_data,
  output logic             flush,
  output logic             upd_valid,
  output logic [15:0]      upd_pc,
  output logic [15:0]      upd_target,
  output logic             upd_taken,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam logic [3:0] OP_BNE = 4'd0;
  localparam logic [3:0] OP_BEQ = 4'd1;
  localparam logic [3:0] OP_BGZ = 4'd2;
  localparam logic [3:0] OP_BLZ = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd9;
  localparam logic [3:0] OP_JAL = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  state_t state_reg, state_next;

  // -------------------------------------------------------------------------
  // Decode and next-PC computation (purely combinational)
  // -------------------------------------------------------------------------
  logic [3:0]  opcode;
  logic [5:0]  func;
  logic [15:0] imm_sext;
  logic [15:0] pc_inc;
  logic [15:0] br_target;
  logic [15:0] jmp_target;
  logic        is_ctrl;
  logic        taken;
  logic [15:0] target;
  logic [15:0] actual_pc;
  logic        mispredict;
  logic        resolve;

  assign opcode     = ex_instruction[15:12];
  assign func       = ex_instruction[5:0];
  assign imm_sext   = {{8{ex_instruction[7]}}, ex_instruction[7:0]};
  assign pc_inc     = ex_pc + 16'd1;
  assign br_target  = pc_inc + imm_sext;   // wraps mod 2^16
  assign jmp_target = {ex_pc[15:12], ex_instruction[11:0]};

  always_comb begin
    is_ctrl = 1'b0;
    taken   = 1'b0;
    target  = pc_inc;
    case (opcode)
      OP_BNE: begin
        is_ctrl = 1'b1;
        taken   = (ex_rs_data != ex_rt_data);
        target  = br_target;
      end
      OP_BEQ: begin
        is_ctrl = 1'b1;
        taken   = (ex_rs_data == ex_rt_data);
        target  = br_target;
      end
      OP_BGZ: begin
        is_ctrl = 1'b1;
        // signed > 0: sign bit clear and not zero
        taken   = !ex_rs_data[15] && (ex_rs_data != 16'd0);
        target  = br_target;
      end
      OP_BLZ: begin
        is_ctrl = 1'b1;
        taken   = ex_rs_data[15];
        target  = br_target;
      end
      OP_JMP, OP_JAL: begin
        is_ctrl = 1'b1;
        taken   = 1'b1;
        target  = jmp_target;
      end
      OP_RTYPE: begin
        if (func == FN_JPR || func == FN_JRL) begin
          is_ctrl = 1'b1;
          taken   = 1'b1;
          target  = ex_rs_data;
        end
      end
      default: begin
        is_ctrl = 1'b0;
        taken   = 1'b0;
        target  = pc_inc;
      end
    endcase
  end

  // A not-taken branch still reports its computed target in the update
  // record, but the machine continues at pc+1.
  assign actual_pc  = taken ? target : pc_inc;
  assign mispredict = (actual_pc != ex_pred_pc);

  // Only an IDLE cycle can consume an instruction; the cycle after a
  // redirect always holds wrong-path contents.
  assign resolve = ex_valid && !ex_stall && (state_reg == IDLE);

  // -------------------------------------------------------------------------
  // FSM: state register + next-state / registered-output inputs
  // -------------------------------------------------------------------------
  logic redirect_next;
  logic upd_next;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    redirect_next = 1'b0;
    upd_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (resolve) begin
          upd_next = is_ctrl;
          if (mispredict) begin
            redirect_next = 1'b1;
            state_next    = REDIRECT;
          end
        end
      end
      REDIRECT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registered outputs
  // -------------------------------------------------------------------------
  logic        force_pc_reg;
  logic        flush_reg;
  logic [15:0] force_pc_data_reg;
  logic        upd_valid_reg;
  logic [15:0] upd_pc_reg;
  logic [15:0] upd_target_reg;
  logic        upd_taken_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      force_pc_reg      <= 1'b0;
      flush_reg         <= 1'b0;
      force_pc_data_reg <= 16'd0;
      upd_valid_reg     <= 1'b0;
      upd_pc_reg        <= 16'd0;
      upd_target_reg    <= 16'd0;
      upd_taken_reg     <= 1'b0;
    end else begin
      // Strobes are single-cycle; data fields hold between strobes.
      force_pc_reg  <= redirect_next;
      flush_reg     <= redirect_next;
      upd_valid_reg <= upd_next;
      if (redirect_next) begin
        force_pc_data_reg <= actual_pc;
      end
      if (upd_next) begin
        upd_pc_reg     <= ex_pc;
        upd_target_reg <= target;
        upd_taken_reg  <= taken;
      end
    end
  end

  assign force_pc      = force_pc_reg;
  assign flush         = flush_reg;
  assign force_pc_data = force_pc_data_reg;
  assign upd_valid     = upd_valid_reg;
  assign upd_pc        = upd_pc_reg;
  assign upd_target    = upd_target_reg;
  assign upd_taken     = upd_taken_reg;

  // -------------------------------------------------------------------------
  // Saturating statistics counters: [0] branches, [1] mispredicts
  // -------------------------------------------------------------------------
  logic [1:0] cnt_inc;
  assign cnt_inc = {redirect_next, upd_next};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        cnt_reg <= '0;
      end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign branch_count     = g_cnt[0].cnt_reg;
  assign mispredict_count = g_cnt[1].cnt_reg;

endmodule
